axis_serdes_rx_checker: RTL

//  AXI4-Stream slave that receives the 32-bit word stream produced by the SERDES FMC stream master.

---
 rtl/axis_rx_pkg.sv | 21 ++
 rtl/axis_rx_fifo.sv | 58 +++++
 rtl/axis_serdes_rx_checker.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/axis_rx_pkg.sv
// Shared types and helpers for the SERDES AXI4-Stream receive checker.
package axis_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPkt,
    StDiscard
  } rxState_e;

  localparam int unsigned CntWidth = 16;

  // FIFO entry layout is {last, strb, data}.
  function automatic int unsigned entryWidth(input int unsigned dataWidth);
    return dataWidth + dataWidth / 8 + 1;
  endfunction

  function automatic logic [CntWidth-1:0] satInc(input logic [CntWidth-1:0] val);
    return (val == {CntWidth{1'b1}}) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/axis_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is always presented on rdData.
module axis_rx_fifo #(
  parameter int unsigned Width = 37,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     push,
  input  logic [Width-1:0]         wrData,
  input  logic                     pop,
  output logic [Width-1:0]         rdData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wrPtrQ, rdPtrQ;
  logic [PtrW:0]    countQ;
  logic             doPush, doPop;

  assign full   = (countQ == (PtrW + 1)'(Depth));
  assign empty  = (countQ == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign rdData = mem[rdPtrQ];
  assign count  = countQ;

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtrQ] <= wrData;
    end
  end

  // Depth is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (doPush) begin
        wrPtrQ <= wrPtrQ + 1'b1;
      end
      if (doPop) begin
        rdPtrQ <= rdPtrQ + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
    end
  end

endmodule

// File: rtl/axis_serdes_rx_checker.sv
// AXI4-Stream sink for the SERDES loopback: buffers beats, limits packet length, keeps stats.
// Optional pattern checker enabled by defining AXIS_RX_PATTERN_CHECK_EN.
module axis_serdes_rx_checker
  import axis_rx_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH    = 32,
  parameter int unsigned          FIFO_DEPTH    = 16,
  parameter int unsigned          MAX_PKT_WORDS = 10,
  parameter logic [DATA_WIDTH-1:0] PATTERN_SEED = 'h1
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [DATA_WIDTH-1:0]             S_AXIS_TDATA,
  input  logic [DATA_WIDTH/8-1:0]           S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic                              rd_en,
  output logic [DATA_WIDTH+DATA_WIDTH/8:0]  rd_data,
  output logic                              rd_empty,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
  output logic [CntWidth-1:0]               pkt_count,
  output logic [CntWidth-1:0]               err_count,
  output logic                              len_err,
  input  logic                              clr_stats
);

  localparam int unsigned EntryW = entryWidth(DATA_WIDTH);
  localparam int unsigned BeatW  = $clog2(MAX_PKT_WORDS + 1);

  rxState_e          stateQ, stateD;
  logic [BeatW-1:0]  beatCntQ, beatCntD, beatNext;
  logic              activeQ;
  logic              fifoFull;
  logic              accept, push, pushLast, lenErrSet;
  logic [CntWidth-1:0] pktCntQ;
  logic              lenErrQ;

  // activeQ keeps TREADY low while in reset, since the FIFO reads as not-full then.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      activeQ <= 1'b0;
    end else begin
      activeQ <= 1'b1;
    end
  end

  assign S_AXIS_TREADY = activeQ && ((stateQ == StDiscard) || !fifoFull);
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign beatNext      = beatCntQ + 1'b1;

  always_comb begin
    stateD    = stateQ;
    beatCntD  = beatCntQ;
    push      = 1'b0;
    pushLast  = S_AXIS_TLAST;
    lenErrSet = 1'b0;
    if (accept) begin
      case (stateQ)
        StIdle: begin
          push     = 1'b1;
          beatCntD = BeatW'(1);
          if (!S_AXIS_TLAST) begin
            stateD = StPkt;
          end
        end
        StPkt: begin
          push     = 1'b1;
          beatCntD = beatNext;
          if (S_AXIS_TLAST) begin
            stateD = StIdle;
          end else if (beatNext == BeatW'(MAX_PKT_WORDS)) begin
            // Terminate the stored packet here and drop the rest of it.
            pushLast  = 1'b1;
            lenErrSet = 1'b1;
            stateD    = StDiscard;
          end
        end
        StDiscard: begin
          if (S_AXIS_TLAST) begin
            stateD = StIdle;
          end
        end
        default: stateD = StIdle;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      stateQ   <= StIdle;
      beatCntQ <= '0;
    end else begin
      stateQ   <= stateD;
      beatCntQ <= beatCntD;
    end
  end

  axis_rx_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk    (ACLK),
    .rstN   (ARESETN),
    .push   (push),
    .wrData ({pushLast, S_AXIS_TSTRB, S_AXIS_TDATA}),
    .pop    (rd_en),
    .rdData (rd_data),
    .full   (fifoFull),
    .empty  (rd_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pktCntQ <= '0;
      lenErrQ <= 1'b0;
    end else if (clr_stats) begin
      pktCntQ <= '0;
      lenErrQ <= 1'b0;
    end else begin
      if (push && pushLast) begin
        pktCntQ <= satInc(pktCntQ);
      end
      if (lenErrSet) begin
        lenErrQ <= 1'b1;
      end
    end
  end

  assign pkt_count = pktCntQ;
  assign len_err   = lenErrQ;

`ifdef AXIS_RX_PATTERN_CHECK_EN
  logic [DATA_WIDTH-1:0] expectedQ;
  logic [CntWidth-1:0]   errCntQ;

  // After a mismatch, resynchronise to the received word.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      expectedQ <= PATTERN_SEED;
      errCntQ   <= '0;
    end else if (clr_stats) begin
      expectedQ <= PATTERN_SEED;
      errCntQ   <= '0;
    end else if (push) begin
      if (S_AXIS_TDATA != expectedQ) begin
        errCntQ   <= satInc(errCntQ);
        expectedQ <= S_AXIS_TDATA + 1'b1;
      end else begin
        expectedQ <= expectedQ + 1'b1;
      end
    end
  end

  assign err_count = errCntQ;
`else
  logic unusedSeed;
  assign unusedSeed = ^PATTERN_SEED;
  assign err_count  = '0;
`endif

endmodule
